// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - Fetch queue sizing, IF_ID_PACKET type and helpers.
package fetch_queue_pkg;

  localparam int N      = 3;
  localparam int SIZE   = 8;
  localparam int IDX_W  = $clog2(SIZE);
  localparam int CNT_W  = $clog2(SIZE + 1);
  localparam int DISP_W = $clog2(N + 1);
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] NPC;
    logic [31:0] PC;
    logic        predict_taken;
  } IF_ID_PACKET;

  localparam IF_ID_PACKET EMPTY_PACKET = '{
    valid: 1'b0, inst: NOP, NPC: 32'd0, PC: 32'd0, predict_taken: 1'b0
  };

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - Fetch/decode/dispatch bus around the fetch queue.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic              squash;
  IF_ID_PACKET       if_packet    [N];
  logic [DISP_W-1:0] dispatch_cnt;
  IF_ID_PACKET       if_id_packet [N];
  logic [CNT_W-1:0]  fq_free_cnt;
  logic [CNT_W-1:0]  fq_count;

  modport master (
    output squash, if_packet, dispatch_cnt,
    input  if_id_packet, fq_free_cnt, fq_count
  );

  modport slave (
    input  squash, if_packet, dispatch_cnt,
    output if_id_packet, fq_free_cnt, fq_count
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - Circular instruction buffer between fetch and decode.
// Optional FETCH_QUEUE_BYPASS_EN: empty queue forwards if_packet to if_id_packet in 0 cycles.
module fetch_queue
  import fetch_queue_pkg::*;
(
  input logic          clock,
  input logic          reset,
  fetch_queue_if.slave bus
);

  IF_ID_PACKET       entries [SIZE];
  logic [IDX_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, free_q, count_next;

  logic [N-1:0]      in_valid;
  logic [CNT_W-1:0]  n_in, n_acc, n_avail, n_pop, n_skip, n_deq, n_write;
  logic              bypass;

  logic              lane_we   [N];
  logic [IDX_W-1:0]  lane_idx  [N];
  logic              entry_we  [SIZE];
  logic [LANE_W-1:0] entry_sel [SIZE];

  always_comb begin
    for (int i = 0; i < N; i++) in_valid[i] = bus.if_packet[i].valid;
  end

  assign n_in  = popcount(in_valid);
  assign n_acc = min_cnt(n_in, free_q);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && !bus.squash;
`else
  assign bypass = 1'b0;
`endif

  // In bypass the visible lanes are the incoming ones, so pops consume them
  // first and only the remainder is stored.
  assign n_avail    = bypass ? n_acc : min_cnt(count_q, CNT_W'(N));
  assign n_pop      = min_cnt(CNT_W'(bus.dispatch_cnt), n_avail);
  assign n_skip     = bypass ? n_pop : '0;
  assign n_deq      = bypass ? '0 : n_pop;
  assign n_write    = n_acc - n_skip;
  assign count_next = count_q + n_write - n_deq;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      lane_we[k]  = (CNT_W'(k) >= n_skip) && (CNT_W'(k) < n_acc);
      lane_idx[k] = tail_q + IDX_W'(CNT_W'(k) - n_skip);
    end
  end

  always_comb begin
    for (int e = 0; e < SIZE; e++) begin
      entry_we[e]  = 1'b0;
      entry_sel[e] = '0;
      for (int k = 0; k < N; k++) begin
        if (lane_we[k] && (lane_idx[k] == IDX_W'(e))) begin
          entry_we[e]  = 1'b1;
          entry_sel[e] = LANE_W'(k);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !bus.squash) begin
      for (int e = 0; e < SIZE; e++) begin
        if (entry_we[e]) entries[e] <= bus.if_packet[entry_sel[e]];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || bus.squash) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= CNT_W'(SIZE);
    end else begin
      head_q  <= head_q + IDX_W'(n_deq);
      tail_q  <= tail_q + IDX_W'(n_write);
      count_q <= count_next;
      free_q  <= CNT_W'(SIZE) - count_next;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.if_id_packet[i] = EMPTY_PACKET;
      if (bypass) begin
        if (bus.if_packet[i].valid) bus.if_id_packet[i] = bus.if_packet[i];
      end else if (CNT_W'(i) < count_q) begin
        bus.if_id_packet[i]       = entries[head_q + IDX_W'(i)];
        bus.if_id_packet[i].valid = 1'b1;
      end
    end
  end

  assign bus.fq_count    = count_q;
  assign bus.fq_free_cnt = free_q;

  a_no_overflow: assert property (@(posedge clock) disable iff (reset || bus.squash)
    n_in <= free_q);
  a_pop_legal: assert property (@(posedge clock) disable iff (reset || bus.squash)
    CNT_W'(bus.dispatch_cnt) <= n_avail);
  a_count_free: assert property (@(posedge clock) disable iff (reset)
    (count_q + free_q) == CNT_W'(SIZE));

endmodule
